// File: rtl/halftone_pkg.sv
// Shared constants, thresholds and state encoding for the halftone cell pipeline.
package halftone_pkg;

    localparam int CELL     = 5;
    localparam int CELL_PIX = 25;
    localparam int SUM_W    = 13;

    localparam logic [SUM_W-1:0] TH3 = 13'd1600;
    localparam logic [SUM_W-1:0] TH2 = 13'd3200;
    localparam logic [SUM_W-1:0] TH1 = 13'd4800;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_QUANT,
        S_WAIT_C,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_t;

endpackage

// File: rtl/halftone_quantize.sv
// Maps a 25-pixel cell sum to a 2-bit dot size; darker cells get larger dots.
module halftone_quantize
    import halftone_pkg::*;
(
    input  logic [SUM_W-1:0] i_sum,
    output logic [1:0]       o_level
);

    always_comb begin
        o_level = 2'd0;
        if (i_sum < TH3)      o_level = 2'd3;
        else if (i_sum < TH2) o_level = 2'd2;
        else if (i_sum < TH1) o_level = 2'd1;
    end

endmodule

// File: rtl/halftone_cell_sched.sv
// Frame sequencer: reads each 5x5 cell, sums it, drives makeCircle and writes the
// returned dot mask into the 1-bit frame buffer.
module halftone_cell_sched
    import halftone_pkg::*;
#(
    parameter int CELLS_X = 2,
    parameter int CELLS_Y = 1,
    parameter int PIX_W   = 8,
    parameter int ADDR_W  = 16,
    parameter int RD_LAT  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic [1:0]        size_level,
    input  logic [24:0]       c_matrix,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_bit,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] W_PIX  = ADDR_W'(CELL * CELLS_X);
    localparam logic [ADDR_W-1:0] CELL_A = ADDR_W'(CELL);
    localparam logic [ADDR_W-1:0] LAST_X = ADDR_W'(CELLS_X - 1);
    localparam logic [ADDR_W-1:0] LAST_Y = ADDR_W'(CELLS_Y - 1);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_cell_x, r_cell_y;
    logic [2:0]        r_row, r_col;
    logic [RD_LAT-1:0] r_vld_pipe;
    logic [SUM_W-1:0]  r_sum;
    logic [4:0]        r_cnt;
    logic [1:0]        r_size_level;

    logic              w_last_k;
    logic              w_acc;
    logic [4:0]        w_k;
    logic [ADDR_W-1:0] w_addr;
    logic [1:0]        w_level;

    assign w_last_k = (r_row == 3'd4) && (r_col == 3'd4);
    assign w_acc    = r_vld_pipe[RD_LAT-1];
    assign w_k      = 5'(r_row) * 5'd5 + 5'(r_col);
    assign w_addr   = (CELL_A * r_cell_y + ADDR_W'(r_row)) * W_PIX
                    + CELL_A * r_cell_x + ADDR_W'(r_col);

    halftone_quantize u_quant (
        .i_sum   (r_sum),
        .o_level (w_level)
    );

    // Outputs decode straight from registered state so reset zeroes them at once.
    assign rd_en      = (r_state == S_READ);
    assign wr_en      = (r_state == S_WRITE);
    assign rd_addr    = rd_en ? w_addr : '0;
    assign wr_addr    = wr_en ? w_addr : '0;
    assign wr_bit     = wr_en & c_matrix[w_k];
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign size_level = r_size_level;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_READ;
            S_READ:   if (w_last_k) w_state_nxt = S_DRAIN;
            // Leave as the 25th sample lands so DRAIN lasts exactly RD_LAT cycles.
            S_DRAIN:  if ((r_cnt == 5'(CELL_PIX)) ||
                          ((r_cnt == 5'(CELL_PIX - 1)) && w_acc)) w_state_nxt = S_QUANT;
            S_QUANT:  w_state_nxt = S_WAIT_C;
            S_WAIT_C: w_state_nxt = S_WRITE;
            S_WRITE:  if (w_last_k) w_state_nxt = S_NEXT;
            S_NEXT:   w_state_nxt = ((r_cell_x != LAST_X) || (r_cell_y != LAST_Y)) ? S_READ : S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cell_x     <= '0;
            r_cell_y     <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_vld_pipe   <= '0;
            r_sum        <= '0;
            r_cnt        <= '0;
            r_size_level <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) r_vld_pipe[i] <= r_vld_pipe[i-1];
            r_vld_pipe[0] <= rd_en;
            if (w_acc) begin
                r_sum <= r_sum + SUM_W'(rd_data);
                r_cnt <= r_cnt + 5'd1;
            end
            case (r_state)
                S_IDLE: begin
                    r_cell_x   <= '0;
                    r_cell_y   <= '0;
                    r_row      <= '0;
                    r_col      <= '0;
                    r_vld_pipe <= '0;
                    r_sum      <= '0;
                    r_cnt      <= '0;
                end
                S_READ, S_WRITE: begin
                    if (r_col == 3'd4) begin
                        r_col <= '0;
                        r_row <= (r_row == 3'd4) ? 3'd0 : r_row + 3'd1;
                    end else begin
                        r_col <= r_col + 3'd1;
                    end
                end
                S_QUANT: r_size_level <= w_level;
                S_NEXT: begin
                    r_sum <= '0;
                    r_cnt <= '0;
                    r_row <= '0;
                    r_col <= '0;
                    if (r_cell_x != LAST_X) begin
                        r_cell_x <= r_cell_x + 1'b1;
                    end else begin
                        r_cell_x <= '0;
                        if (r_cell_y != LAST_Y) r_cell_y <= r_cell_y + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_halftone_cell_sched.sv
// Directed bench: default 2x1 frame (A) and 2x2 address sweep (B) with RAM and makeCircle models.
module tb_halftone_cell_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Deliberately asymmetric masks so bit-index errors show up.
    function automatic logic [24:0] mask_of(input logic [1:0] l);
        case (l)
            2'd0:    return 25'h0001000;
            2'd1:    return 25'h0A5A5A5;
            2'd2:    return 25'h1234567;
            default: return 25'h1F0F0F3;
        endcase
    endfunction

    // ---------------- DUT A: 2x1 cells ----------------
    logic        rst_a, start_a, rd_en_a, wr_en_a, wr_bit_a, busy_a, done_a, clr_a;
    logic [15:0] rd_addr_a, wr_addr_a;
    logic [7:0]  rd_data_a;
    logic [1:0]  sl_a;
    logic [24:0] cm_a;

    halftone_cell_sched #(.CELLS_X(2), .CELLS_Y(1), .PIX_W(8), .ADDR_W(16), .RD_LAT(2)) u_dut_a (
        .clk(clk), .reset(rst_a), .start(start_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
        .rd_data(rd_data_a), .size_level(sl_a), .c_matrix(cm_a), .wr_en(wr_en_a),
        .wr_addr(wr_addr_a), .wr_bit(wr_bit_a), .busy(busy_a), .done(done_a)
    );

    logic [7:0]  ram_a [0:49];
    logic [1:0]  va_a = '0;
    logic [15:0] aa0_a = '0, aa1_a = '0;
    always @(posedge clk) begin
        va_a  <= {va_a[0], rd_en_a};
        aa1_a <= aa0_a;
        aa0_a <= rd_addr_a;
    end
    assign rd_data_a = (va_a[1] && aa1_a < 16'd50) ? ram_a[aa1_a] : 8'hFF;

    always @(posedge clk or posedge rst_a)
        if (rst_a) cm_a <= '0;
        else       cm_a <= mask_of(sl_a);

    int          wc_a [50];
    logic        fb_a [50];
    logic [1:0]  lvl_a [2];
    int          nwr_a, nrd_a, ndone_a, ovl_a, oob_a, first_rd_a, done_cyc_a;
    logic [15:0] first_ra_a, last_wa_a;

    always @(negedge clk) begin
        if (clr_a) begin
            for (int p = 0; p < 50; p++) begin wc_a[p] = 0; fb_a[p] = 1'b0; end
            lvl_a[0] = 2'bxx; lvl_a[1] = 2'bxx;
            nwr_a = 0; nrd_a = 0; ndone_a = 0; ovl_a = 0; oob_a = 0;
            first_rd_a = -1; done_cyc_a = -1; first_ra_a = 16'hFFFF; last_wa_a = 16'hFFFF;
        end else begin
            if (rd_en_a && wr_en_a) ovl_a++;
            if (rd_en_a) begin
                if (first_rd_a < 0) begin first_rd_a = cyc; first_ra_a = rd_addr_a; end
                nrd_a++;
            end
            if (wr_en_a) begin
                nwr_a++;
                last_wa_a = wr_addr_a;
                if (wr_addr_a < 16'd50) begin
                    wc_a[wr_addr_a]++;
                    fb_a[wr_addr_a] = wr_bit_a;
                    lvl_a[(int'(wr_addr_a) % 10) / 5] = sl_a;
                end else oob_a++;
            end
            if (done_a) begin ndone_a++; done_cyc_a = cyc; end
        end
    end

    // ---------------- DUT B: 2x2 cells ----------------
    logic        rst_b, start_b, rd_en_b, wr_en_b, wr_bit_b, busy_b, done_b, clr_b;
    logic [15:0] rd_addr_b, wr_addr_b;
    logic [7:0]  rd_data_b;
    logic [1:0]  sl_b;
    logic [24:0] cm_b;

    halftone_cell_sched #(.CELLS_X(2), .CELLS_Y(2), .PIX_W(8), .ADDR_W(16), .RD_LAT(2)) u_dut_b (
        .clk(clk), .reset(rst_b), .start(start_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
        .rd_data(rd_data_b), .size_level(sl_b), .c_matrix(cm_b), .wr_en(wr_en_b),
        .wr_addr(wr_addr_b), .wr_bit(wr_bit_b), .busy(busy_b), .done(done_b)
    );

    logic [1:0] vb = '0;
    always @(posedge clk) vb <= {vb[0], rd_en_b};
    assign rd_data_b = vb[1] ? 8'd0 : 8'hFF;

    always @(posedge clk or posedge rst_b)
        if (rst_b) cm_b <= '0;
        else       cm_b <= mask_of(sl_b);

    int          wc_b [100];
    int          nwr_b, ndone_b, nent_b, first_rd_b, done_cyc_b, badbit_b;
    logic [15:0] ent_b [4];
    logic [15:0] last_wa_b;
    logic        prev_rd_b;
    logic [24:0] m3;

    always @(negedge clk) begin
        if (clr_b) begin
            for (int p = 0; p < 100; p++) wc_b[p] = 0;
            for (int e = 0; e < 4; e++) ent_b[e] = 16'hFFFF;
            nwr_b = 0; ndone_b = 0; nent_b = 0; first_rd_b = -1; done_cyc_b = -1;
            badbit_b = 0; last_wa_b = 16'hFFFF; prev_rd_b = 1'b0; m3 = mask_of(2'd3);
        end else begin
            if (rd_en_b && !prev_rd_b) begin
                if (nent_b < 4) ent_b[nent_b] = rd_addr_b;
                nent_b++;
            end
            if (rd_en_b && first_rd_b < 0) first_rd_b = cyc;
            prev_rd_b = rd_en_b;
            if (wr_en_b) begin
                nwr_b++;
                last_wa_b = wr_addr_b;
                if (wr_addr_b < 16'd100) begin
                    wc_b[wr_addr_b]++;
                    if (wr_bit_b !== m3[5 * ((int'(wr_addr_b) / 10) % 5) + (int'(wr_addr_b) % 5)])
                        badbit_b++;
                end
            end
            if (done_b) begin ndone_b++; done_cyc_b = cyc; end
        end
    end

    // ---------------- directed sequence ----------------
    task automatic fill_a(input logic [7:0] v0, input logic [7:0] v1);
        for (int p = 0; p < 50; p++) ram_a[p] = ((p % 10) < 5) ? v0 : v1;
    endtask

    task automatic check_a_reset();
        chk("rst_rd_en", rd_en_a, 0);
        chk("rst_rd_addr", rd_addr_a, 0);
        chk("rst_size_level", sl_a, 0);
        chk("rst_wr_en", wr_en_a, 0);
        chk("rst_wr_addr", wr_addr_a, 0);
        chk("rst_wr_bit", wr_bit_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
    endtask

    task automatic run_a(input logic [1:0] l0, input logic [1:0] l1, input bit inject);
        logic [24:0] m;
        int x, y;
        clr_a = 1'b1; step(); clr_a = 1'b0;
        chk("a_busy_idle", busy_a, 0);
        start_a = 1'b1; step(); start_a = 1'b0;
        chk("a_busy_rise", busy_a, 1);
        chk("a_rd_first", rd_en_a, 1);
        for (int i = 0; i < 300 && ndone_a == 0; i++) begin
            start_a = inject && (i == 20 || i == 80);
            step();
        end
        start_a = inject;
        step();
        start_a = 1'b0;
        chk("a_done_pulse", done_a, 0);
        chk("a_busy_fall", busy_a, 0);
        repeat (4) step();
        chk("a_busy_after", busy_a, 0);
        chk("a_ndone", ndone_a, 1);
        chk("a_nwr", nwr_a, 50);
        chk("a_nrd", nrd_a, 50);
        chk("a_overlap", ovl_a, 0);
        chk("a_oob", oob_a, 0);
        chk("a_done_latency", done_cyc_a - first_rd_a, 110);
        chk("a_first_rd_addr", first_ra_a, 0);
        chk("a_last_wr_addr", last_wa_a, 49);
        chk("a_level_cell0", lvl_a[0], l0);
        chk("a_level_cell1", lvl_a[1], l1);
        for (int p = 0; p < 50; p++) begin
            x = p % 10;
            y = p / 10;
            m = mask_of((x < 5) ? l0 : l1);
            chk($sformatf("a_wcnt_%0d", p), wc_a[p], 1);
            chk($sformatf("a_bit_%0d", p), fb_a[p], m[5 * y + (x % 5)]);
        end
    endtask

    initial begin
        int once;
        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        clr_a = 1'b1; clr_b = 1'b1;
        fill_a(8'd0, 8'd0);
        repeat (3) step();
        check_a_reset();
        chk("rst_b_busy", busy_b, 0);
        rst_a = 1'b0; rst_b = 1'b0;
        clr_a = 1'b0; clr_b = 1'b0;
        step();

        // All black source: both cells largest dot.
        run_a(2'd3, 2'd3, 1'b0);
        // All white: sum 6375, smallest dot.
        fill_a(8'd255, 8'd255);
        run_a(2'd0, 2'd0, 1'b0);
        // Strict threshold: 1600 -> level 2, 1575 -> level 3.
        fill_a(8'd64, 8'd63);
        run_a(2'd2, 2'd3, 1'b0);
        // Extra start pulses mid-frame and during DONE are ignored.
        fill_a(8'd0, 8'd0);
        run_a(2'd3, 2'd3, 1'b1);

        // Reset during cell 1 WRITE, then a clean full frame.
        fill_a(8'd64, 8'd63);
        clr_a = 1'b1; step(); clr_a = 1'b0;
        start_a = 1'b1; step(); start_a = 1'b0;
        for (int i = 0; i < 200 && nwr_a < 30; i++) step();
        chk("a_in_cell1_write", wr_en_a, 1);
        rst_a = 1'b1;
        #1;
        check_a_reset();
        step();
        rst_a = 1'b0;
        step();
        run_a(2'd2, 2'd3, 1'b0);

        // Address sweep on the 2x2 instance.
        clr_b = 1'b1; step(); clr_b = 1'b0;
        start_b = 1'b1; step(); start_b = 1'b0;
        for (int i = 0; i < 400 && ndone_b == 0; i++) step();
        repeat (3) step();
        chk("b_entries", nent_b, 4);
        chk("b_cell0_addr", ent_b[0], 0);
        chk("b_cell1_addr", ent_b[1], 5);
        chk("b_cell2_addr", ent_b[2], 50);
        chk("b_cell3_addr", ent_b[3], 55);
        chk("b_last_wr_addr", last_wa_b, 99);
        chk("b_nwr", nwr_b, 100);
        chk("b_badbit", badbit_b, 0);
        chk("b_ndone", ndone_b, 1);
        chk("b_done_latency", done_cyc_b - first_rd_b, 220);
        once = 0;
        for (int p = 0; p < 100; p++) if (wc_b[p] == 1) once++;
        chk("b_written_once", once, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/halftone_cell_sched.md
# halftone_cell_sched

Sequencer for the halftone pipeline. It walks a grayscale source frame in 5×5-pixel cells and, for each cell:
- reads the 25 pixels and sums them;
- quantizes the sum to a 2-bit dot size and drives the `makeCircle` generator;
- writes the returned 25-bit dot mask, one bit per pixel, into the 1-bit output frame buffer.

It sits between the source pixel RAM, the `makeCircle` instance and the halftone frame buffer. It is the only master of all three.

## Interface
Parameters:
- CELLS_X, 2: cells per row; image width W = 5·CELLS_X.
- CELLS_Y, 1: cell rows; image height H = 5·CELLS_Y.
- PIX_W, 8: grayscale pixel width.
- ADDR_W, 16: address width for both memories; must hold W·H−1.
- RD_LAT, 2: source RAM read latency in cycles, ≥1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle request to process a full frame; ignored while busy.
- rd_en  out  1  source read strobe.
- rd_addr  out  ADDR_W  source pixel address.
- rd_data  in  PIX_W  source pixel, valid exactly RD_LAT cycles after the matching rd_en.
- size_level  out  2  to makeCircle sizeLevel; held constant from QUANT through WRITE.
- c_matrix  in  25  from makeCircle cMatrix; registered there, valid 1 cycle after size_level changes.
- wr_en  out  1  frame-buffer write strobe.
- wr_addr  out  ADDR_W  frame-buffer pixel address.
- wr_bit  out  1  1 = black dot pixel.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse when the last write of the frame has been issued.

## Operation
- States: IDLE, READ, DRAIN, QUANT, WAIT_C, WRITE, NEXT, DONE.
- IDLE:
  - start=1 → READ.
  - Clear cell_x, cell_y, the pixel index k, the accumulator and the valid pipeline.
- READ: 25 cycles with rd_en=1.
  - k = 0..24, row r = k/5, col c = k%5.
  - rd_addr = (5·cell_y + r)·W + 5·cell_x + c.
  - After k=24 → DRAIN.
- Valid pipeline: rd_en delayed by RD_LAT cycles.
  - Each valid cycle adds zero-extended rd_data to the 13-bit sum; max 25·255 = 6375, no overflow.
  - A counter tracks accepted samples.
- DRAIN: wait until 25 samples have been accepted → QUANT.
- QUANT: register size_level from sum.
  - sum < 1600 → 3 (largest dot, darkest).
  - sum < 3200 → 2.
  - sum < 4800 → 1.
  - otherwise → 0.
  - Comparisons are strict.
  - Next state WAIT_C.
- WAIT_C: one cycle for makeCircle to register → WRITE.
- WRITE: 25 cycles with wr_en=1.
  - k = 0..24.
  - wr_addr uses the same formula as rd_addr.
  - wr_bit = c_matrix[5·r + c].
  - After k=24 → NEXT.
- NEXT: clear sum and counters, then:
  - cell_x < CELLS_X−1: cell_x+1 → READ.
  - Otherwise cell_x=0; if cell_y < CELLS_Y−1, cell_y+1 → READ.
  - Otherwise → DONE.
- DONE: done=1 for one cycle → IDLE.
- start while busy: ignored, no queuing.
- start in the same cycle as DONE: ignored. A new frame needs start in IDLE.
- reset mid-frame: immediate return to IDLE with all outputs 0. No partial-cell completion. Writes already issued stay in memory.

## Timing
- Reset value of every output: 0 (rd_en, rd_addr, size_level, wr_en, wr_addr, wr_bit, busy, done).
- busy rises the cycle after start is sampled and falls the cycle after done.
- Per-cell latency, READ entry to next READ entry: 25 + RD_LAT + 1 + 1 + 25 + 1 = 53 + RD_LAT cycles (55 at default).
- Frame: first rd_en the cycle after start. done pulses (53 + RD_LAT)·CELLS_X·CELLS_Y cycles after the first rd_en.
- rd_en and wr_en are never high in the same cycle.
- wr_en is high for exactly 25 consecutive cycles per cell.

## Structure
- Shared package halftone_pkg:
  - CELL = 5, CELL_PIX = 25.
  - SUM_W = 13.
  - Thresholds TH3 = 1600, TH2 = 3200, TH1 = 4800.
  - State enum.
  - makeCircle also uses CELL.
- Natural sub-module halftone_quantize: combinational sum → size_level. It is reusable by a future adaptive-threshold path.
- Everything else lives in one FSM plus counters.

## Test plan
Default parameters (CELLS_X=2, CELLS_Y=1, RD_LAT=2) unless stated; RAM model honors RD_LAT.
- All pixels 0, start → size_level=3 for both cells; 50 writes with wr_bit=c_matrix bits; done 110 cycles after the first rd_en.
- All pixels 255 → sum 6375, size_level=0 for both cells; written bits equal makeCircle level-0 mask.
- Cell 0 all 64 (sum 1600), cell 1 all 63 (sum 1575) → cell 0 size_level=2, cell 1 size_level=3 (strict boundary).
- Address sweep with CELLS_X=2, CELLS_Y=2 → second cell's first rd_addr=5; third cell's first rd_addr=50; last wr_addr=99; each address written exactly once.
- start pulsed again mid-frame → ignored; exactly 50 writes and one done pulse.
- reset asserted during cell 1 WRITE → all outputs 0 in the same cycle. A new start then restarts from rd_addr=0 with a correct full frame.
